// File: rtl/fft_reorder_buf_if.sv
// Stream bundle for the FFT bit-reversal reorder buffer.
// Carries the bit-reversed input stream and the natural-order ready/valid output stream.
interface fft_reorder_buf_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LOG2_POINTS = 4
);
  logic                   di_en;
  logic [DATA_WIDTH-1:0]  di_re;
  logic [DATA_WIDTH-1:0]  di_im;
  logic                   do_valid;
  logic                   do_ready;
  logic [DATA_WIDTH-1:0]  do_re;
  logic [DATA_WIDTH-1:0]  do_im;
  logic [LOG2_POINTS-1:0] do_index;
  logic                   do_last;
  logic                   ovf;

  // Upstream FFT plus downstream consumer
  modport master (
    output di_en, di_re, di_im, do_ready,
    input  do_valid, do_re, do_im, do_index, do_last, ovf
  );

  // Reorder buffer
  modport slave (
    input  di_en, di_re, di_im, do_ready,
    output do_valid, do_re, do_im, do_index, do_last, ovf
  );
endinterface

// File: rtl/fft_reorder_buf.sv
// Bit-reversal reorder buffer: captures bit-reversed FFT frames into a two-bank
// ping-pong memory and replays them in natural bin order with back-pressure.
module fft_reorder_buf #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LOG2_POINTS = 4
) (
  input  logic          clk,
  input  logic          rstn,
  fft_reorder_buf_if.slave bus
);

  localparam int unsigned              N    = 1 << LOG2_POINTS;
  localparam logic [LOG2_POINTS-1:0]   LAST = LOG2_POINTS'(N - 1);

  function automatic logic [LOG2_POINTS-1:0] bitrev(input logic [LOG2_POINTS-1:0] a);
    logic [LOG2_POINTS-1:0] r;
    for (int i = 0; i < int'(LOG2_POINTS); i++) r[i] = a[LOG2_POINTS-1-i];
    return r;
  endfunction

  // Banks are intentionally not reset
  logic [2*DATA_WIDTH-1:0] r_mem [2][N];

  logic [LOG2_POINTS-1:0] r_wcnt;
  logic                   r_wsel;
  logic                   r_drop;
  logic                   r_ovf;
  logic [1:0]             r_full;
  logic [LOG2_POINTS-1:0] r_rcnt;
  logic                   r_rsel;
  logic                   r_do_valid;
  logic [DATA_WIDTH-1:0]  r_do_re;
  logic [DATA_WIDTH-1:0]  r_do_im;
  logic [LOG2_POINTS-1:0] r_do_index;
  logic                   r_do_last;

  logic                    w_start;
  logic                    w_drop_now;
  logic                    w_wr;
  logic                    w_wlast;
  logic                    w_adv;
  logic                    w_rd;
  logic                    w_rlast;
  logic [1:0]              w_full_d;
  logic [2*DATA_WIDTH-1:0] w_rd_word;

  // Write/read side decode; a frame's drop decision uses the registered full flag
  always_comb begin
    w_start    = bus.di_en && (r_wcnt == '0);
    w_drop_now = w_start ? r_full[r_wsel] : r_drop;
    w_wr       = bus.di_en && !w_drop_now;
    w_wlast    = (r_wcnt == LAST);
    w_adv      = !r_do_valid || bus.do_ready;
    w_rd       = w_adv && r_full[r_rsel];
    w_rlast    = (r_rcnt == LAST);
    w_rd_word  = r_mem[r_rsel][r_rcnt];
  end

  // Full flags: writer sets its bank, reader clears its bank (never the same one)
  always_comb begin
    w_full_d = r_full;
    if (w_wr && w_wlast) w_full_d[r_wsel] = 1'b1;
    if (w_rd && w_rlast) w_full_d[r_rsel] = 1'b0;
  end

  // Sample memory write at the bit-reversed address
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wsel][bitrev(r_wcnt)] <= {bus.di_re, bus.di_im};
  end

  // Write-side counter, bank select, drop and sticky overflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wcnt <= '0;
      r_wsel <= 1'b0;
      r_drop <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.di_en) begin
      r_wcnt <= r_wcnt + 1'b1;
      if (w_start && r_full[r_wsel]) begin
        r_drop <= 1'b1;
        r_ovf  <= 1'b1;
      end
      if (w_wlast) begin
        if (w_drop_now) r_drop <= 1'b0;
        else            r_wsel <= ~r_wsel;
      end
    end else begin
      // di_en low mid-frame aborts; partial bank is reused by the next frame
      r_wcnt <= '0;
      r_drop <= 1'b0;
    end
  end

  // Bank full flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_full <= '0;
    else       r_full <= w_full_d;
  end

  // Read side and output register; holds everything while stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rcnt     <= '0;
      r_rsel     <= 1'b0;
      r_do_valid <= 1'b0;
      r_do_re    <= '0;
      r_do_im    <= '0;
      r_do_index <= '0;
      r_do_last  <= 1'b0;
    end else if (w_adv) begin
      if (w_rd) begin
        r_do_valid <= 1'b1;
        r_do_re    <= w_rd_word[2*DATA_WIDTH-1:DATA_WIDTH];
        r_do_im    <= w_rd_word[DATA_WIDTH-1:0];
        r_do_index <= r_rcnt;
        r_do_last  <= w_rlast;
        r_rcnt     <= r_rcnt + 1'b1;
        if (w_rlast) r_rsel <= ~r_rsel;
      end else begin
        r_do_valid <= 1'b0;
      end
    end
  end

  assign bus.do_valid = r_do_valid;
  assign bus.do_re    = r_do_re;
  assign bus.do_im    = r_do_im;
  assign bus.do_index = r_do_index;
  assign bus.do_last  = r_do_last;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Self-checking bench for fft_reorder_buf (N = 16): ramp table, back-pressure,
// continuous frames, overflow, abort and reset during readout.
module tb_fft_reorder_buf;

  logic clk;
  logic rstn;

  fft_reorder_buf_if #(.DATA_WIDTH(16), .LOG2_POINTS(4)) bus ();

  fft_reorder_buf #(.DATA_WIDTH(16), .LOG2_POINTS(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_re;
    logic [3:0]  exp_idx;
    logic        exp_last;
  } vec_t;

  vec_t tbl [16];
  int   n_cmp = 0;
  int   n_err = 0;

  // Accepted output samples
  logic [15:0] q_re  [$];
  logic [15:0] q_im  [$];
  logic [3:0]  q_idx [$];
  logic        q_last[$];

  int rdy_mode = 1;  // 0 low, 1 high, 2 pattern 1,0,0,1
  int run_len  = 0;
  int max_run  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bitrev4(input int k);
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction

  // Ready driver: the only writer of do_ready
  initial begin
    int pat [4] = '{1, 0, 0, 1};
    int cnt = 0;
    bus.do_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0)      bus.do_ready = 1'b0;
      else if (rdy_mode == 1) bus.do_ready = 1'b1;
      else begin
        bus.do_ready = pat[cnt % 4] != 0;
        cnt++;
      end
    end
  end

  // Output monitor: records accepted samples and checks stability while stalled
  initial begin
    logic        stall_prev = 1'b0;
    logic [15:0] h_re, h_im;
    logic [3:0]  h_idx;
    logic        h_last;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (stall_prev) begin
          check("stall hold valid", 32'(bus.do_valid), 1);
          check("stall hold re",    32'(bus.do_re),    32'(h_re));
          check("stall hold im",    32'(bus.do_im),    32'(h_im));
          check("stall hold index", 32'(bus.do_index), 32'(h_idx));
          check("stall hold last",  32'(bus.do_last),  32'(h_last));
        end
        if (bus.do_valid && bus.do_ready) begin
          q_re.push_back(bus.do_re);
          q_im.push_back(bus.do_im);
          q_idx.push_back(bus.do_index);
          q_last.push_back(bus.do_last);
        end
        stall_prev = bus.do_valid && !bus.do_ready;
        h_re = bus.do_re; h_im = bus.do_im; h_idx = bus.do_index; h_last = bus.do_last;
        if (bus.do_valid) begin
          run_len++;
          if (run_len > max_run) max_run = run_len;
        end else run_len = 0;
      end else stall_prev = 1'b0;
    end
  end

  task automatic clear_q();
    q_re.delete(); q_im.delete(); q_idx.delete(); q_last.delete();
  endtask

  // Leaves the caller at posedge+2 with reset released
  task automatic do_reset();
    rstn = 1'b0;
    bus.di_en = 1'b0;
    bus.di_re = '0;
    bus.di_im = '0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    clear_q();
  endtask

  // n samples, re = re_base + step*j, im = im_base + step*j; di_en left high
  task automatic send_frame(input int n, input int re_base, input int im_base, input int step);
    for (int j = 0; j < n; j++) begin
      bus.di_en = 1'b1;
      bus.di_re = 16'(re_base + step * j);
      bus.di_im = 16'(im_base + step * j);
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle(input int n);
    bus.di_en = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_count(input int n, input string name);
    int t = 0;
    while (q_re.size() < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #2;
    check(name, 32'(q_re.size() >= n), 1);
  endtask

  initial begin
    int exp_list [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    bit found;
    for (int j = 0; j < 16; j++) begin
      tbl[j].din      = 16'(j);
      tbl[j].exp_re   = 16'(exp_list[j]);
      tbl[j].exp_idx  = 4'(j);
      tbl[j].exp_last = (j == 15);
    end

    // Reset state
    rdy_mode = 1;
    do_reset();
    @(negedge clk);
    check("reset do_valid", 32'(bus.do_valid), 0);
    check("reset do_re",    32'(bus.do_re),    0);
    check("reset do_im",    32'(bus.do_im),    0);
    check("reset do_index", 32'(bus.do_index), 0);
    check("reset do_last",  32'(bus.do_last),  0);
    check("reset ovf",      32'(bus.ovf),      0);
    @(posedge clk); #2;

    // Ramp frame from the table, latency check
    for (int j = 0; j < 16; j++) begin
      bus.di_en = 1'b1;
      bus.di_re = tbl[j].din;
      bus.di_im = '0;
      @(posedge clk);
      #2;
    end
    bus.di_en = 1'b0;
    @(negedge clk);
    check("ramp valid before latency", 32'(bus.do_valid), 0);
    @(negedge clk);
    check("ramp valid after 1 cycle", 32'(bus.do_valid), 1);
    check("ramp first index", 32'(bus.do_index), 0);
    wait_count(16, "ramp count");
    for (int k = 0; k < 16 && k < q_re.size(); k++) begin
      check($sformatf("ramp re[%0d]", k),    32'(q_re[k]),   32'(tbl[k].exp_re));
      check($sformatf("ramp index[%0d]", k), 32'(q_idx[k]),  32'(tbl[k].exp_idx));
      check($sformatf("ramp last[%0d]", k),  32'(q_last[k]), 32'(tbl[k].exp_last));
    end
    clear_q();

    // Back-pressure with ready pattern 1,0,0,1
    rdy_mode = 2;
    send_frame(16, 0, 0, 1);
    idle(1);
    wait_count(16, "bp count");
    idle(10);
    check("bp no extra", 32'(q_re.size()), 16);
    for (int k = 0; k < 16 && k < q_re.size(); k++) begin
      check($sformatf("bp re[%0d]", k),    32'(q_re[k]),  32'(tbl[k].exp_re));
      check($sformatf("bp index[%0d]", k), 32'(q_idx[k]), k);
    end
    clear_q();

    // Continuous frames, no gap expected
    rdy_mode = 1;
    idle(3);
    max_run = 0;
    for (int f = 0; f < 4; f++) send_frame(16, 16 * f, 100 * f, 1);
    idle(1);
    wait_count(64, "cont count");
    idle(3);
    check("cont longest valid run", max_run, 64);
    check("cont ovf", 32'(bus.ovf), 0);
    for (int i = 0; i < 64 && i < q_re.size(); i++) begin
      check($sformatf("cont re[%0d]", i), 32'(q_re[i]), 16 * (i / 16) + bitrev4(i % 16));
      check($sformatf("cont im[%0d]", i), 32'(q_im[i]), 100 * (i / 16) + bitrev4(i % 16));
    end
    clear_q();

    // Overflow: third frame must be dropped
    do_reset();
    rdy_mode = 0;
    idle(2);
    for (int f = 1; f <= 3; f++) send_frame(16, 256 * f, f, 1);
    idle(2);
    check("ovf set", 32'(bus.ovf), 1);
    check("ovf nothing accepted", 32'(q_re.size()), 0);
    rdy_mode = 1;
    wait_count(32, "ovf count");
    idle(40);
    check("ovf no frame 3 data", 32'(q_re.size()), 32);
    for (int i = 0; i < 32 && i < q_re.size(); i++) begin
      check($sformatf("ovf re[%0d]", i), 32'(q_re[i]), 256 * (1 + i / 16) + bitrev4(i % 16));
    end
    check("ovf still set", 32'(bus.ovf), 1);
    clear_q();

    // Abort: 7-sample fragment, gap, then a full frame of 0x55
    do_reset();
    send_frame(7, 16'h11, 16'h11, 0);
    idle(2);
    send_frame(16, 16'h55, 16'h55, 0);
    idle(1);
    wait_count(16, "abort count");
    idle(20);
    check("abort no fragment output", 32'(q_re.size()), 16);
    for (int k = 0; k < 16 && k < q_re.size(); k++) begin
      check($sformatf("abort re[%0d]", k), 32'(q_re[k]), 16'h55);
      check($sformatf("abort im[%0d]", k), 32'(q_im[k]), 16'h55);
    end
    clear_q();

    // Reset during readout at bin 5
    send_frame(16, 16'h200, 0, 1);
    bus.di_en = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (bus.do_valid && bus.do_index == 4'd5) found = 1'b1;
    end
    check("rst reached bin 5", 32'(found), 1);
    #1 rstn = 1'b0;
    #1;
    check("rst do_valid immediate", 32'(bus.do_valid), 0);
    check("rst do_index immediate", 32'(bus.do_index), 0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    clear_q();
    idle(3);
    check("rst nothing after release", 32'(q_re.size()), 0);
    send_frame(16, 16'h300, 16'h40, 1);
    idle(1);
    wait_count(16, "rst new frame count");
    for (int k = 0; k < 16 && k < q_re.size(); k++) begin
      check($sformatf("rst re[%0d]", k),    32'(q_re[k]),  16'h300 + bitrev4(k));
      check($sformatf("rst im[%0d]", k),    32'(q_im[k]),  16'h40 + bitrev4(k));
      check($sformatf("rst index[%0d]", k), 32'(q_idx[k]), k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_reorder_buf.md
# fft_reorder_buf

Bit-reversal reorder buffer placed directly downstream of the R2SDF FFT pipeline. It captures each N-point frame the FFT emits in bit-reversed order on its `do_en`/`do_re`/`do_im` stream and writes it into one bank of a two-bank ping-pong memory. It then streams the frame out in natural bin order (bin 0 to N-1) on a ready/valid interface with back-pressure. This replaces ad-hoc result RAMs and lets a downstream consumer stall without losing frames.

## Interface
- `DATA_WIDTH`, default 16: width of the real and imaginary samples.
- `LOG2_POINTS`, default 4: log2 of the FFT size; N = 2^LOG2_POINTS.

- `clk`  in  1: single clock; all logic is on the rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `di_en`  in  1: input sample valid; a frame is N consecutive high cycles.
- `di_re`  in  DATA_WIDTH: input real part, bit-reversed order.
- `di_im`  in  DATA_WIDTH: input imaginary part.
- `do_valid`  out  1: output sample valid.
- `do_ready`  in  1: consumer accepts the output sample.
- `do_re`  out  DATA_WIDTH: output real part, natural order.
- `do_im`  out  DATA_WIDTH: output imaginary part.
- `do_index`  out  LOG2_POINTS: bin index k of the current output.
- `do_last`  out  1: high with bin N-1.
- `ovf`  out  1: sticky; a frame was dropped because no bank was free.

## Operation
- Storage: two banks, each N x 2·DATA_WIDTH. Banks are not reset. Each bank has a `full[b]` flag.
- Write side: write counter `wcnt` (LOG2_POINTS bits), bank select `wsel`, and a `drop` flag.
  - Frame start is a cycle with `di_en` high and `wcnt == 0`. If `full[wsel]` is set at that point, set `drop` and `ovf`; the whole frame is discarded.
  - Each `di_en` cycle: if `drop` is clear, write bank[wsel][bitrev(wcnt)]. Then increment `wcnt`.
  - On the cycle that writes `wcnt == N-1` (not dropped), set `full[wsel]` and toggle `wsel`.
  - On the cycle with `wcnt == N-1` of a dropped frame, clear `drop`. `wsel` does not toggle.
  - `di_en` low while `wcnt != 0` aborts the frame: `wcnt` returns to 0 and `drop` clears. The partial bank is not marked full and is overwritten by the next frame.
- Read side: read counter `rcnt` and read bank `rsel`.
  - The output register advances when `!do_valid || do_ready`.
  - On advance, if `full[rsel]` is set: load `do_re`, `do_im` from bank[rsel][rcnt], set `do_index = rcnt`, `do_last = (rcnt == N-1)`, set `do_valid = 1`, and increment `rcnt`.
  - When the loaded sample is `rcnt == N-1`, clear `full[rsel]` and toggle `rsel` in the same cycle.
  - On advance with `full[rsel]` clear, `do_valid` goes to 0.
- While `do_valid && !do_ready`, all outputs hold stable.
- Simultaneous events:
  - Write-side set and read-side clear of `full` always target different banks.
  - If the write side checks `full[wsel]` at frame start in the same cycle the read side clears it, the frame is still dropped, because the check uses the registered value.
- `ovf` clears only on reset.

## Timing
- Reset values: `do_valid`, `do_re`, `do_im`, `do_index`, `do_last`, `ovf` are 0. `wcnt`, `rcnt`, `wsel`, `rsel`, `full[*]`, `drop` are 0.
- Reset asserted mid-frame or mid-readout discards all buffered data immediately.
- Latency: the edge that writes the last sample of a frame sets `full`. Bin 0 appears with `do_valid` on the following edge (1 cycle).
- Throughput: with `do_ready` held high, one sample per cycle. Back-to-back frames come out with no bubble when the next bank is already full.
- Input has no back-pressure. Continuous input is sustained only if the consumer averages one accept per cycle.

## Test plan
- Ramp frame, N=16: input `di_re` = 0..15 in one burst, `do_ready` high.
  - Required: `do_re` sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - Required: `do_index` 0..15, `do_last` only on the 16th sample, first `do_valid` exactly 1 cycle after the last input.
- Back-pressure: same frame with `do_ready` toggling 1,0,0,1 repeatedly.
  - Required: same 16 values in the same order, none repeated or lost, outputs stable on every stalled cycle.
- Continuous frames: 4 back-to-back frames, `di_im` = 100·f + j, `do_ready` high.
  - Required: 64 consecutive valid cycles with no gap, each frame reordered correctly, `ovf` = 0.
- Overflow: `do_ready` low, send 3 frames.
  - Required: frames 1 and 2 buffered, frame 3 dropped, `ovf` = 1.
  - Then raise `do_ready`: frame 1 then frame 2 are output, and no data from frame 3 appears.
- Abort: 7 samples, `di_en` low for 2 cycles, then a full frame of value 0x55.
  - Required: 16 outputs all 0x55, no output from the 7-sample fragment.
- Reset mid-readout: assert `rstn` low at output bin 5.
  - Required: `do_valid` = 0 immediately. After release, a new frame is output correctly starting at bin 0.
